dmem_bridge: RTL
================

Name: dmem_bridge

Overview:
- Memory-stage data-memory bridge. It sits directly downstream of the pipelined datapath's M-stage outputs and returns `read_dataM` to it.
- Converts each load/store in M into a valid/ready request on an external memory bus and waits for the read response.
- Stalls the pipeline until the access completes.
- Flags misaligned addresses and bus timeouts as errors.

Parameters:
- AW, 32, address width
- DW, 32, data width
- TW, 8, timeout counter width
- TIMEOUT, 255, cycles allowed in REQ+RESP before abort; must be ≤ 2^TW−1

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  asynchronous, active-low reset
- alu_outM  in  AW  M-stage effective address
- write_dataM  in  DW  M-stage store data
- mem_writeM  in  1  M-stage store
- mem_readM  in  1  M-stage load (driven from mem_to_regM)
- read_dataM  out  DW  load data; valid in DONE cycle, held otherwise
- stallM  out  1  freeze F/D/E/M pipeline registers
- mem_errM  out  1  one-cycle error pulse (misaligned or timeout)
- req_valid  out  1  bus request valid
- req_ready  in  1  bus accepts request
- req_we  out  1  1 = write
- req_addr  out  AW  word-aligned request address
- req_wdata  out  DW  write data
- resp_valid  in  1  read response valid
- resp_rdata  in  DW  read response data

Behaviour:
- Reset (rst=0, asynchronous):
  - state=IDLE, timeout counter=0.
  - req_valid=0, req_we=0, req_addr=0, req_wdata=0.
  - read_dataM=0, mem_errM=0; stallM=0 combinationally.
  - Reset mid-transaction aborts immediately; no response is awaited afterwards.
- Access definition: access = mem_readM | mem_writeM. If both are set, the store wins.
- Aligned means alu_outM[1:0]==2'b00.
- FSM states: IDLE, REQ, RESP, DONE.
- IDLE:
  - Aligned access: stallM=1 combinationally. Capture addr, wdata and we into req_* registers. Clear the counter. Next state REQ.
  - Misaligned access: no bus request and stallM=0. mem_errM=1 for the following cycle. read_dataM<=0. Stay in IDLE.
  - No access: stay in IDLE, stallM=0.
- REQ:
  - req_valid=1 and stallM=1.
  - req_addr, req_we and req_wdata are stable while req_valid=1.
  - On req_valid & req_ready: write → DONE; read → RESP. Counter increments each cycle.
- RESP:
  - req_valid=0, stallM=1.
  - On resp_valid: read_dataM<=resp_rdata, next state DONE.
  - resp_valid is ignored in every other state.
- Timeout: in REQ or RESP, when the counter reaches TIMEOUT without completion:
  - Next state DONE; read_dataM<=0; mem_errM pulses 1 in the DONE cycle.
  - req_valid drops. This is the only permitted request withdrawal.
- DONE:
  - stallM=0, so the pipeline advances at the end of this cycle and the W register samples read_dataM.
  - Next state IDLE. An access presented in DONE is not evaluated until IDLE.
- Latency:
  - Read with zero-wait bus: stallM high 3 cycles (IDLE-detect, REQ, RESP), then DONE.
  - Write with zero-wait bus: stallM high 2 cycles.
- read_dataM holds its last value outside DONE. Stores never modify it.
- mem_errM is never asserted together with req_valid.
- At most one outstanding bus transaction.

Test Plan:
- Load: mem_readM=1, alu_outM=0x100; req_ready=1 in REQ; resp_valid=1 with 0xCAFEF00D one cycle later → req_addr=0x100, req_we=0; stallM high exactly 3 cycles; read_dataM=0xCAFEF00D in DONE; mem_errM=0.
- Store with backpressure: mem_writeM=1, addr 0x20, data 0x12345678; req_ready held low 4 cycles → req_valid/addr/wdata stable for all 5 REQ cycles; stallM high 6 cycles; read_dataM unchanged.
- Misaligned load: alu_outM=0x102 → no req_valid; stallM=0; mem_errM=1 for one cycle; read_dataM=0.
- Timeout: TIMEOUT=8; load accepted, resp_valid never asserted → DONE reached after 8 counted cycles; mem_errM=1; read_dataM=0; FSM returns to IDLE. A stray resp_valid afterwards is ignored.
- Reset mid-RESP: rst=0 asynchronously while waiting → req_valid=0, stallM=0, read_dataM=0 immediately; after release, a new load completes normally.
- Back-to-back: load then store on consecutive M instructions → two distinct bus transactions in order; second request begins only after DONE→IDLE.

Source files
------------

// File: rtl/dmem_bridge.sv
// ---------------------------------------------------------------------------
// dmem_bridge
//
// Memory-stage data-memory bridge. Each load or store presented by the
// M stage becomes one valid/ready request on an external memory bus. The
// bridge holds the pipeline with stallM until the access finishes. Loads
// also wait for the read response. Misaligned addresses and bus timeouts are
// reported as a one-cycle error pulse.
//
// Ports
//   clk          clock; all state updates on the rising edge
//   rst          asynchronous, active-low reset
//   alu_outM     M-stage effective address
//   write_dataM  M-stage store data
//   mem_writeM   M-stage store
//   mem_readM    M-stage load
//   read_dataM   load data; valid in the DONE cycle, held otherwise
//   stallM       freezes the F/D/E/M pipeline registers
//   mem_errM     one-cycle error pulse (misaligned or timeout)
//   req_valid    bus request valid
//   req_ready    bus accepts request
//   req_we       request is a write
//   req_addr     word-aligned request address
//   req_wdata    request write data
//   resp_valid   read response valid
//   resp_rdata   read response data
// ---------------------------------------------------------------------------
module dmem_bridge #(
   parameter int AW      = 32,
   parameter int DW      = 32,
   parameter int TW      = 8,
   parameter int TIMEOUT = 255
) (
   input  logic          clk,
   input  logic          rst,
   input  logic [AW-1:0] alu_outM,
   input  logic [DW-1:0] write_dataM,
   input  logic          mem_writeM,
   input  logic          mem_readM,
   output logic [DW-1:0] read_dataM,
   output logic          stallM,
   output logic          mem_errM,
   output logic          req_valid,
   input  logic          req_ready,
   output logic          req_we,
   output logic [AW-1:0] req_addr,
   output logic [DW-1:0] req_wdata,
   input  logic          resp_valid,
   input  logic [DW-1:0] resp_rdata
);

   typedef enum logic [1:0] {
      IDLE,
      REQ,
      RESP,
      DONE
   } stateT;

   stateT         state;
   logic [TW-1:0] timeoutCount;
   logic          isAccess;
   logic          isAligned;
   logic          timeoutHit;

   // The counter starts at zero in the first REQ cycle. The abort happens in
   // the cycle that would otherwise be one past TIMEOUT cycles spent in REQ
   // and RESP together, so the last counted cycle is the one where the
   // counter reads TIMEOUT-1.
   assign isAccess   = mem_readM | mem_writeM;
   assign isAligned  = (alu_outM[1:0] == 2'b00);
   assign timeoutHit = (timeoutCount == TW'(TIMEOUT - 1));

   // The stall must rise in the same cycle the access is first seen.
   // Otherwise the pipeline would move the instruction out of M before the
   // bridge has captured it. It is gated by reset so an aborted transaction
   // frees the pipeline at once.
   assign stallM = rst & (((state == IDLE) && isAccess && isAligned) ||
                          (state == REQ) || (state == RESP));

   // Single transaction FSM. Every bus-facing output and the load data are
   // registered here. mem_errM defaults low each cycle, which gives it its
   // one-cycle pulse shape. A store that times out leaves read_dataM alone
   // because stores never touch the load data.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state        <= IDLE;
         timeoutCount <= '0;
         req_valid    <= 1'b0;
         req_we       <= 1'b0;
         req_addr     <= '0;
         req_wdata    <= '0;
         read_dataM   <= '0;
         mem_errM     <= 1'b0;
      end else begin
         mem_errM <= 1'b0;
         case (state)
            IDLE: begin
               if (isAccess) begin
                  if (isAligned) begin
                     req_valid    <= 1'b1;
                     req_we       <= mem_writeM;
                     req_addr     <= alu_outM;
                     req_wdata    <= write_dataM;
                     timeoutCount <= '0;
                     state        <= REQ;
                  end else begin
                     mem_errM   <= 1'b1;
                     read_dataM <= '0;
                  end
               end
            end
            REQ: begin
               timeoutCount <= timeoutCount + TW'(1);
               if (req_ready) begin
                  req_valid <= 1'b0;
                  state     <= req_we ? DONE : RESP;
               end else if (timeoutHit) begin
                  req_valid <= 1'b0;
                  mem_errM  <= 1'b1;
                  if (!req_we) begin
                     read_dataM <= '0;
                  end
                  state <= DONE;
               end
            end
            RESP: begin
               timeoutCount <= timeoutCount + TW'(1);
               if (resp_valid) begin
                  read_dataM <= resp_rdata;
                  state      <= DONE;
               end else if (timeoutHit) begin
                  read_dataM <= '0;
                  mem_errM   <= 1'b1;
                  state      <= DONE;
               end
            end
            DONE: begin
               state <= IDLE;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule
